data_memory_responder: RTL and testbench

Responder end of the core's load and store channels. It accepts load and store requests from the back end's load unit and store buffer, and arbitrates them onto a single-port, byte-enabled data SRAM. It returns load data after a fixed configurable latency and acknowledges stores. It sits outside the core, between the load/store units and on-chip data memory.

---
 rtl/apogeo_pkg.sv | 60 ++++++
 rtl/dmem_channels.sv | 27 ++
 rtl/data_memory_bank.sv | 106 ++++++++++
 rtl/data_memory_responder.sv | 176 +++++++++++++++++
 tb/tb_data_memory_responder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/apogeo_pkg.sv
// apogeo_pkg
// Shared types, constants and helpers for the data memory responder.
//   store_width_t    : store access width carried on the store channel
//   dmem_state_t     : RAM-port FSM state
//   MAX_LOAD_LATENCY : upper bound of the LOAD_LATENCY parameter
//   store_lanes()    : expands a store into byte enables + lane-replicated data
//   lane_parity()    : even-parity bit for each byte lane of a word
package apogeo_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } store_width_t;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } dmem_state_t;

    localparam int MAX_LOAD_LATENCY = 8;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } store_lanes_t;

    // Address low bits that do not fit the access width are ignored, which
    // forces natural alignment. Data is replicated across lanes so that the
    // byte enables alone select what lands in the RAM.
    function automatic store_lanes_t store_lanes(input store_width_t width,
                                                 input logic [1:0]   lane,
                                                 input logic [31:0]  data);
        store_lanes_t s;
        s.be   = 4'b0000;
        s.data = data;
        case (width)
            BYTE: begin
                s.be   = 4'b0001 << lane;
                s.data = {4{data[7:0]}};
            end
            HALF: begin
                s.be   = lane[1] ? 4'b1100 : 4'b0011;
                s.data = {2{data[15:0]}};
            end
            WORD:    s.be = 4'b1111;
            default: s.be = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] lane_parity(input logic [31:0] word);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^word[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dmem_channels.sv
// load_interface / store_interface
// Request/response channels between the core's load unit / store buffer and
// the data memory responder.
//   load_interface : request, address[31:0] (to memory); data[31:0], valid (back)
//   store_interface: request, address[31:0], data[31:0], width (to memory); done (back)
interface load_interface;
    logic        request;
    logic [31:0] address;
    logic [31:0] data;
    logic        valid;

    modport master (output request, address, input  data, valid);
    modport slave  (input  request, address, output data, valid);
endinterface

interface store_interface;
    import apogeo_pkg::*;

    logic         request;
    logic [31:0]  address;
    logic [31:0]  data;
    store_width_t width;
    logic         done;

    modport master (output request, address, data, width, input  done);
    modport slave  (input  request, address, data, width, output done);
endinterface

// File: rtl/data_memory_bank.sv
// data_memory_bank
// Single-port, 4-lane byte-enabled data RAM with a registered read and a
// LOAD_LATENCY-deep output pipeline. Optional per-lane even parity storage
// when the DMEM_PARITY_EN macro is defined.
// Ports:
//   clk, rst_n         : clock, async active-low reset (valid bits only)
//   rd_en, rd_idx      : read request and word index
//   wr_en, wr_idx      : write request and word index
//   wr_be, wr_data     : byte enables and lane-aligned write data
//   rd_valid, rd_data  : read result, LOAD_LATENCY cycles after rd_en
//   rd_error           : parity mismatch on the returned word, with rd_valid
module data_memory_bank
    import apogeo_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int LOAD_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [3:0]               wr_be,
    input  logic [31:0]              wr_data,
    output logic                     rd_valid,
    output logic [31:0]              rd_data,
    output logic                     rd_error
);

    logic [3:0][7:0]       mem        [DEPTH];
    // Stage 0 is the RAM read register; stages 1..LOAD_LATENCY follow it.
    logic                  pipe_valid [LOAD_LATENCY+1];
    logic [31:0]           pipe_data  [LOAD_LATENCY+1];
    logic [LOAD_LATENCY:1] err_sr;
    logic                  q_err;

    // NOTE: the RAM array and data pipeline have no reset; only the valid
    // bits do. Resetting a memory array prevents SRAM mapping and is never
    // needed when every consumer is qualified by a reset valid bit.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            pipe_data[0] <= mem[rd_idx];
        end
        // Data only advances behind a valid entry, so the output holds its
        // last returned word between pulses.
        for (int k = 1; k <= LOAD_LATENCY; k++) begin
            if (pipe_valid[k-1]) begin
                pipe_data[k] <= pipe_data[k-1];
            end
        end
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][i] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its predecessor regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LOAD_LATENCY; k++) begin
                pipe_valid[k] <= 1'b0;
            end
            err_sr <= '0;
        end else begin
            pipe_valid[0] <= rd_en;
            for (int k = 1; k <= LOAD_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
            end
            // Mismatch is evaluated on the stage-0 word and then travels
            // alongside its valid bit.
            err_sr <= (err_sr << 1) | LOAD_LATENCY'(q_err);
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par [DEPTH];
    logic [3:0] par_q;

    always_ff @(posedge clk) begin
        if (rd_en) begin
            par_q <= par[rd_idx];
        end
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    par[wr_idx][i] <= ^wr_data[8*i +: 8];
                end
            end
        end
    end

    assign q_err = |(par_q ^ lane_parity(pipe_data[0]));
`else
    assign q_err = 1'b0;
`endif

    assign rd_valid = pipe_valid[LOAD_LATENCY];
    assign rd_data  = pipe_data[LOAD_LATENCY];
    assign rd_error = pipe_valid[LOAD_LATENCY] & err_sr[LOAD_LATENCY];

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder
// Arbitrates the core's load and store channels onto one single-port,
// byte-enabled data SRAM. Loads return the aligned word LOAD_LATENCY cycles
// after service; stores are acknowledged one cycle after the RAM write.
// Optional parity checking is enabled by defining DMEM_PARITY_EN.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   load_channel   : load_interface.slave  (request, address -> data, valid)
//   store_channel  : store_interface.slave (request, address, data, width -> done)
//   load_error_o   : parity error on returned load word, pulses with valid
//   idle_o         : no pending or live request and RAM port free
module data_memory_responder
    import apogeo_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int LOAD_LATENCY = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    load_interface.slave  load_channel,
    store_interface.slave store_channel,
    output logic          load_error_o,
    output logic          idle_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_LOAD_LATENCY);

    dmem_state_t   state;
    logic [CW-1:0] count;

    // Pending registers hold a request that could not be served on arrival.
    logic          ld_pend_valid;
    logic [IW-1:0] ld_pend_idx;
    logic          st_pend_valid;
    logic [IW-1:0] st_pend_idx;
    store_lanes_t  st_pend_lanes;

    logic [IW-1:0] ld_live_idx;
    logic [IW-1:0] st_live_idx;
    store_lanes_t  st_live_lanes;

    logic          ld_avail;
    logic          st_avail;
    logic [IW-1:0] ld_idx;
    logic [IW-1:0] st_idx;
    store_lanes_t  st_lanes;
    logic          ld_fire;
    logic          st_fire;

    logic          st_ack;
    logic          done;
    logic          rd_valid;
    logic [31:0]   rd_data;
    logic          rd_error;
    logic          unused_addr;

    assign ld_live_idx   = load_channel.address[IW+1:2];
    assign st_live_idx   = store_channel.address[IW+1:2];
    assign st_live_lanes = store_lanes(store_channel.width, store_channel.address[1:0],
                                       store_channel.data);
    assign unused_addr   = ^{load_channel.address[31:IW+2], load_channel.address[1:0],
                             store_channel.address[31:IW+2]};

    // Pending beats live. With both channels eligible, a shared word index
    // serves the store first so the load observes it; otherwise the load goes
    // first because its latency is on the core's critical path.
    always_comb begin
        // NOTE: every output gets a default before any condition so no path
        // leaves a variable unassigned, which would infer a latch.
        ld_avail = ld_pend_valid | load_channel.request;
        st_avail = st_pend_valid | store_channel.request;
        ld_idx   = ld_pend_valid ? ld_pend_idx : ld_live_idx;
        st_idx   = st_pend_valid ? st_pend_idx : st_live_idx;
        st_lanes = st_pend_valid ? st_pend_lanes : st_live_lanes;
        ld_fire  = 1'b0;
        st_fire  = 1'b0;
        if (state == IDLE) begin
            if (ld_avail && st_avail) begin
                if (ld_idx == st_idx) begin
                    st_fire = 1'b1;
                end else begin
                    ld_fire = 1'b1;
                end
            end else begin
                ld_fire = ld_avail;
                st_fire = st_avail;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ld_pend_valid <= 1'b0;
            st_pend_valid <= 1'b0;
        end else begin
            if (ld_fire) begin
                ld_pend_valid <= 1'b0;
            end else if (load_channel.request) begin
                ld_pend_valid <= 1'b1;
            end
            if (st_fire) begin
                st_pend_valid <= 1'b0;
            end else if (store_channel.request) begin
                st_pend_valid <= 1'b1;
            end
        end
    end

    // Payloads are qualified by the pending valid bits above.
    always_ff @(posedge clk_i) begin
        if (!ld_fire && load_channel.request) begin
            ld_pend_idx <= ld_live_idx;
        end
        if (!st_fire && store_channel.request) begin
            st_pend_idx   <= st_live_idx;
            st_pend_lanes <= st_live_lanes;
        end
    end

    // The port stays busy while a read is in flight; with LOAD_LATENCY=1 the
    // pipeline alone carries the read and the FSM never leaves IDLE. The exit
    // edge coincides with the valid pulse, so a store may be served then.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            count  <= '0;
            st_ack <= 1'b0;
            done   <= 1'b0;
        end else begin
            st_ack <= st_fire;
            done   <= st_ack;
            case (state)
                IDLE: begin
                    if (ld_fire && LOAD_LATENCY > 1) begin
                        state <= LOAD_WAIT;
                        count <= CW'(LOAD_LATENCY - 1);
                    end
                end
                LOAD_WAIT: begin
                    if (count == '0) begin
                        state <= IDLE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    data_memory_bank #(
        .DEPTH        (DEPTH),
        .LOAD_LATENCY (LOAD_LATENCY)
    ) u_bank (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .rd_en    (ld_fire),
        .rd_idx   (ld_idx),
        .wr_en    (st_fire),
        .wr_idx   (st_idx),
        .wr_be    (st_lanes.be),
        .wr_data  (st_lanes.data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_error (rd_error)
    );

    assign load_channel.valid = rd_valid;
    assign load_channel.data  = rd_data;
    assign store_channel.done = done;
    assign load_error_o       = rd_error;
    assign idle_o             = (state == IDLE) & ~ld_pend_valid & ~st_pend_valid &
                                ~load_channel.request & ~store_channel.request;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
// Directed self-checking bench for data_memory_responder (DEPTH=1024,
// LOAD_LATENCY=2). Parity scenario runs only when DMEM_PARITY_EN is defined.
module tb_data_memory_responder;
    import apogeo_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic load_error;
    logic idle;

    int n_cmp      = 0;
    int n_bad      = 0;
    int proto_errs = 0;
    logic ld_busy;
    logic st_busy;

    load_interface  ld_if ();
    store_interface st_if ();

    data_memory_responder #(
        .DEPTH        (DEPTH),
        .LOAD_LATENCY (LAT)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .load_channel  (ld_if),
        .store_channel (st_if),
        .load_error_o  (load_error),
        .idle_o        (idle)
    );

    always #5 clk = ~clk;

    // Protocol monitor: a new request while the previous one on the same
    // channel has not completed is a bench-side error.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_busy <= 1'b0;
            st_busy <= 1'b0;
        end else begin
            if ((ld_if.request && ld_busy && !ld_if.valid) ||
                (st_if.request && st_busy && !st_if.done)) begin
                proto_errs <= proto_errs + 1;
            end
            if (ld_if.request)    ld_busy <= 1'b1;
            else if (ld_if.valid) ld_busy <= 1'b0;
            if (st_if.request)    st_busy <= 1'b1;
            else if (st_if.done)  st_busy <= 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request cycle; returns just after the accepting edge T.
    task automatic do_req(input logic ld, input logic [31:0] la,
                          input logic st, input logic [31:0] sa,
                          input logic [31:0] sd, input store_width_t sw);
        ld_if.request = ld;
        ld_if.address = la;
        st_if.request = st;
        st_if.address = sa;
        st_if.data    = sd;
        st_if.width   = sw;
        cyc();
        ld_if.request = 1'b0;
        st_if.request = 1'b0;
    endtask

    // Observes max_cyc cycles after edge T; latencies are edges after T
    // (-1 when never seen), counts are number of pulse cycles.
    task automatic watch(input int max_cyc, output int lat_v, output int lat_d,
                         output int cnt_v, output int cnt_d,
                         output logic [31:0] vdata, output logic verr);
        lat_v = -1;
        lat_d = -1;
        cnt_v = 0;
        cnt_d = 0;
        vdata = '0;
        verr  = 1'b0;
        for (int k = 0; k <= max_cyc; k++) begin
            if (k > 0) cyc();
            if (ld_if.valid === 1'b1) begin
                cnt_v++;
                if (lat_v < 0) begin
                    lat_v = k;
                    vdata = ld_if.data;
                    verr  = load_error;
                end
            end
            if (st_if.done === 1'b1) begin
                cnt_d++;
                if (lat_d < 0) lat_d = k;
            end
        end
    endtask

    initial begin
        int          lat_v;
        int          lat_d;
        int          cnt_v;
        int          cnt_d;
        logic [31:0] vdata;
        logic        verr;

        ld_if.request = 1'b0;
        ld_if.address = '0;
        st_if.request = 1'b0;
        st_if.address = '0;
        st_if.data    = '0;
        st_if.width   = WORD;

        // Reset state
        #1;
        check("rst_valid", 32'(ld_if.valid), 32'd0);
        check("rst_done", 32'(st_if.done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        #20;
        rst_n = 1'b1;
        cyc();
        check("idle_after_reset", 32'(idle), 32'd1);

        // Word store then load, uncontended
        do_req(1'b0, '0, 1'b1, 32'h40, 32'hDEADBEEF, WORD);
        watch(4, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("store_done_latency", 32'(lat_d), 32'd1);
        check("store_done_pulses", 32'(cnt_d), 32'd1);
        check("idle_after_store", 32'(idle), 32'd1);

        do_req(1'b1, 32'h40, 1'b0, '0, '0, WORD);
        check("idle_during_load", 32'(idle), 32'd0);
        watch(4, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("load_latency", 32'(lat_v), 32'd2);
        check("load_pulses", 32'(cnt_v), 32'd1);
        check("load_data", vdata, 32'hDEADBEEF);
        check("load_error_clean", 32'(verr), 32'd0);
        check("data_hold", ld_if.data, 32'hDEADBEEF);

        // Upper address bits are ignored
        do_req(1'b1, 32'hABCD_0040, 1'b0, '0, '0, WORD);
        watch(4, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("upper_bits_ignored", vdata, 32'hDEADBEEF);

        // Byte and half stores over a zero word; junk high data bits and a
        // misaligned half address must not matter
        do_req(1'b0, '0, 1'b1, 32'h80, 32'h0000_0000, WORD);
        watch(2, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        do_req(1'b0, '0, 1'b1, 32'h81, 32'hFFFF_FF11, BYTE);
        watch(2, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("byte_store_done", 32'(lat_d), 32'd1);
        do_req(1'b0, '0, 1'b1, 32'h83, 32'h1234_AABB, HALF);
        watch(2, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        do_req(1'b1, 32'h80, 1'b0, '0, '0, WORD);
        watch(4, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("byte_half_merge", vdata, 32'hAABB_1100);

        // Same-cycle load and store to one word: store first, load one late
        do_req(1'b1, 32'h100, 1'b1, 32'h100, 32'h0000_0005, WORD);
        watch(6, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("raw_done_latency", 32'(lat_d), 32'd1);
        check("raw_load_latency", 32'(lat_v), 32'd3);
        check("raw_load_data", vdata, 32'h0000_0005);

        // Same-cycle load and store to different words: load first
        do_req(1'b0, '0, 1'b1, 32'h200, 32'hCAFE_F00D, WORD);
        watch(2, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        do_req(1'b1, 32'h200, 1'b1, 32'h300, 32'h1234_5678, WORD);
        check("idle_contended", 32'(idle), 32'd0);
        watch(6, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("split_load_latency", 32'(lat_v), 32'd2);
        check("split_load_data", vdata, 32'hCAFE_F00D);
        check("split_done_latency", 32'(lat_d), 32'd4);
        check("split_done_pulses", 32'(cnt_d), 32'd1);
        check("idle_after_split", 32'(idle), 32'd1);
        do_req(1'b1, 32'h300, 1'b0, '0, '0, WORD);
        watch(4, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("split_store_data", vdata, 32'h1234_5678);

        // Reset while a load is in flight and a store is pending
        do_req(1'b1, 32'h200, 1'b1, 32'h300, 32'hBAD0_BAD0, WORD);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(ld_if.valid), 32'd0);
        check("midrst_done", 32'(st_if.done), 32'd0);
        check("midrst_idle", 32'(idle), 32'd1);
        cyc();
        cyc();
        rst_n = 1'b1;
        watch(6, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("post_rst_valid_pulses", 32'(cnt_v), 32'd0);
        check("post_rst_done_pulses", 32'(cnt_d), 32'd0);
        check("post_rst_idle", 32'(idle), 32'd1);
        do_req(1'b1, 32'h300, 1'b0, '0, '0, WORD);
        watch(4, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("pending_store_dropped", vdata, 32'h1234_5678);

`ifdef DMEM_PARITY_EN
        // Corrupt one bit in lane 2 behind the parity bits' back
        do_req(1'b0, '0, 1'b1, 32'h10, 32'h0102_0304, WORD);
        watch(2, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        dut.u_bank.mem[4][2] = dut.u_bank.mem[4][2] ^ 8'h01;
        do_req(1'b1, 32'h10, 1'b0, '0, '0, WORD);
        watch(4, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("parity_error_flag", 32'(verr), 32'd1);
        check("parity_data_unmodified", vdata, 32'h0103_0304);
        check("parity_error_pulse_off", 32'(load_error), 32'd0);
        do_req(1'b1, 32'h40, 1'b0, '0, '0, WORD);
        watch(4, lat_v, lat_d, cnt_v, cnt_d, vdata, verr);
        check("parity_clean_word", 32'(verr), 32'd0);
`endif

        check("protocol_errors", 32'(proto_errs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
